system_fifo_drain: RTL and testbench

- Read-side sequencer for the 64-bit system-state FIFOs. The write side fills a FIFO with one word per PV element during a solver step.
- On a step-done pulse, this block issues exactly N_WORDS FIFO read requests, throttled by FIFO empty, and tracks the FIFO read latency.
- It presents each returned word with its element index to the downstream register bank, then pulses done.
- It detects an underrun (the FIFO stays starved) and a step-overrun (a new step starts before the drain completes).

---
 rtl/system_fifo_drain.sv | 195 +++++++++++++++++++
 tb/tb_system_fifo_drain.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/system_fifo_drain.sv
// -----------------------------------------------------------------------------
// system_fifo_drain
//
// Read-side sequencer for a system-state FIFO. A start pulse begins a drain
// that issues exactly N_WORDS read requests (held off while the FIFO is empty).
// Each returned word is presented with its element index, and done pulses once
// at the end of the drain.
// A FIFO that stays starved for TIMEOUT cycles aborts the drain and sets
// err_underrun. A start that arrives while busy sets err_overrun and is
// otherwise ignored.
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   rst_user     synchronous active-high soft abort (same effect as rst)
//   start        single-cycle pulse that begins a drain
//   fifo_empty   FIFO empty flag
//   fifo_q       FIFO read data, valid RD_LATENCY cycles after a request
//   fifo_rdreq   FIFO read request (combinational from state and fifo_empty)
//   out_valid    out_data / out_index valid for this cycle
//   out_data     drained word
//   out_index    element index of out_data, 0..N_WORDS-1
//   done         one-cycle pulse marking the end of a drain
//   busy         high while a drain is in progress (READ or DRAIN)
//   err_underrun sticky: the last drain was aborted by the starvation timeout
//   err_overrun  sticky: start arrived while busy
// -----------------------------------------------------------------------------
module system_fifo_drain #(
  parameter int N_WORDS    = 16,
  parameter int DATA_W     = 64,
  parameter int RD_LATENCY = 1,
  parameter int TIMEOUT    = 64,
  localparam int IDX_W     = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rst_user,
  input  logic              start,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_q,
  output logic              fifo_rdreq,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_index,
  output logic              done,
  output logic              busy,
  output logic              err_underrun,
  output logic              err_overrun
);

  localparam int CNT_W = $clog2(N_WORDS + 1);
  localparam int STL_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] ALL_WORDS   = CNT_W'(N_WORDS);
  localparam logic [CNT_W-1:0] LAST_WORD   = CNT_W'(N_WORDS - 1);
  localparam logic [STL_W-1:0] STALL_LIMIT = STL_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        issued_q, issued_d;
  logic [CNT_W-1:0]        recvd_q, recvd_d;
  logic [STL_W-1:0]        stall_q, stall_d;
  // One bit per outstanding request; the tail marks fifo_q as valid.
  logic [RD_LATENCY-1:0]   pipe_q, pipe_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_W-1:0]       out_data_q, out_data_d;
  logic [IDX_W-1:0]        out_index_q, out_index_d;
  logic                    done_q, done_d;
  logic                    err_under_q, err_under_d;
  logic                    err_over_q, err_over_d;
  logic                    rdreq_w;
  logic                    busy_w;

  assign busy_w  = (state_q != ST_IDLE);
  assign rdreq_w = (state_q == ST_READ) && !fifo_empty && (issued_q < ALL_WORDS);

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    issued_d    = issued_q;
    recvd_d     = recvd_q;
    stall_d     = stall_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    done_d      = 1'b0;
    err_under_d = err_under_q;
    err_over_d  = err_over_q;
    // Shift the new request in at bit 0; the cast drops the old tail bit.
    pipe_d      = RD_LATENCY'({pipe_q, rdreq_w});

    // Word returning from the FIFO: register it for presentation next cycle.
    if (pipe_q[RD_LATENCY-1]) begin
      out_valid_d = 1'b1;
      out_data_d  = fifo_q;
      out_index_d = recvd_q[IDX_W-1:0];
      recvd_d     = recvd_q + CNT_W'(1);
      // The last word of a complete drain carries done with it.
      if (recvd_q == LAST_WORD) begin
        done_d = 1'b1;
      end
    end

    if (start && busy_w) begin
      err_over_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          issued_d    = '0;
          recvd_d     = '0;
          stall_d     = '0;
          err_under_d = 1'b0;
          err_over_d  = 1'b0;
          state_d     = ST_READ;
        end
      end
      ST_READ: begin
        if (rdreq_w) begin
          issued_d = issued_q + CNT_W'(1);
          stall_d  = '0;
          if (issued_q == LAST_WORD) begin
            state_d = ST_DRAIN;
          end
        end else if (issued_q < ALL_WORDS) begin
          stall_d = stall_q + STL_W'(1);
          if (stall_q == STALL_LIMIT) begin
            err_under_d = 1'b1;
            state_d     = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Once nothing is in flight: a complete drain has just pulsed done
        // with its last word and can leave; an aborted drain pulses done now
        // and stays here for that cycle so busy covers the done pulse.
        if (pipe_q == '0) begin
          if (done_q) begin
            state_d = ST_IDLE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst || rst_user) begin
      state_q     <= ST_IDLE;
      issued_q    <= '0;
      recvd_q     <= '0;
      stall_q     <= '0;
      pipe_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      done_q      <= 1'b0;
      err_under_q <= 1'b0;
      err_over_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      issued_q    <= issued_d;
      recvd_q     <= recvd_d;
      stall_q     <= stall_d;
      pipe_q      <= pipe_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      done_q      <= done_d;
      err_under_q <= err_under_d;
      err_over_q  <= err_over_d;
    end
  end

  assign fifo_rdreq   = rdreq_w;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_index    = out_index_q;
  assign done         = done_q;
  assign busy         = busy_w;
  assign err_underrun = err_under_q;
  assign err_overrun  = err_over_q;

endmodule

// File: tb/tb_system_fifo_drain.sv
// -----------------------------------------------------------------------------
// tb_system_fifo_drain
//
// Directed bench for system_fifo_drain with N_WORDS=4, TIMEOUT=8.
// Instance A uses RD_LATENCY=1 and instance B uses RD_LATENCY=3. Each instance
// has its own behavioural FIFO model that returns data RD_LATENCY cycles after
// a request. Cycle k below means the k-th clock period after the one in
// which start is driven high (cycle 0).
// -----------------------------------------------------------------------------
module tb_system_fifo_drain;

  localparam int NW = 4;
  localparam int DW = 64;
  localparam int TO = 8;
  localparam logic [DW-1:0] JUNK = 64'hDEAD_BEEF_DEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst      = 1'b1;
  logic rst_user = 1'b0;
  logic start    = 1'b0;
  logic sel_b    = 1'b0;

  wire start_a = start & ~sel_b;
  wire start_b = start & sel_b;

  // ---------------- instance A (RD_LATENCY = 1) ----------------
  logic          fifo_empty_a, rdreq_a, valid_a, done_a, busy_a, eu_a, eo_a;
  logic [DW-1:0] fifo_q_a, data_a;
  logic [1:0]    index_a;
  logic [DW-1:0] mem_a [0:255];
  int            wr_a = 0;
  int            rd_a = 0;
  logic [DW-1:0] dq_a = JUNK;

  assign fifo_empty_a = (wr_a == rd_a);
  assign fifo_q_a     = dq_a;

  always @(posedge clk) begin
    if (rdreq_a) begin
      dq_a <= mem_a[rd_a];
      rd_a <= rd_a + 1;
    end else begin
      dq_a <= JUNK;
    end
  end

  system_fifo_drain #(.N_WORDS(NW), .DATA_W(DW), .RD_LATENCY(1), .TIMEOUT(TO)) dut_a (
    .clk(clk), .rst(rst), .rst_user(rst_user), .start(start_a),
    .fifo_empty(fifo_empty_a), .fifo_q(fifo_q_a), .fifo_rdreq(rdreq_a),
    .out_valid(valid_a), .out_data(data_a), .out_index(index_a), .done(done_a),
    .busy(busy_a), .err_underrun(eu_a), .err_overrun(eo_a)
  );

  // ---------------- instance B (RD_LATENCY = 3) ----------------
  logic          fifo_empty_b, rdreq_b, valid_b, done_b, busy_b, eu_b, eo_b;
  logic [DW-1:0] fifo_q_b, data_b;
  logic [1:0]    index_b;
  logic [DW-1:0] mem_b [0:255];
  int            wr_b = 0;
  int            rd_b = 0;
  logic [DW-1:0] dq_b0 = JUNK;
  logic [DW-1:0] dq_b1 = JUNK;
  logic [DW-1:0] dq_b2 = JUNK;

  assign fifo_empty_b = (wr_b == rd_b);
  assign fifo_q_b     = dq_b2;

  always @(posedge clk) begin
    if (rdreq_b) begin
      dq_b0 <= mem_b[rd_b];
      rd_b  <= rd_b + 1;
    end else begin
      dq_b0 <= JUNK;
    end
    dq_b1 <= dq_b0;
    dq_b2 <= dq_b1;
  end

  system_fifo_drain #(.N_WORDS(NW), .DATA_W(DW), .RD_LATENCY(3), .TIMEOUT(TO)) dut_b (
    .clk(clk), .rst(rst), .rst_user(rst_user), .start(start_b),
    .fifo_empty(fifo_empty_b), .fifo_q(fifo_q_b), .fifo_rdreq(rdreq_b),
    .out_valid(valid_b), .out_data(data_b), .out_index(index_b), .done(done_b),
    .busy(busy_b), .err_underrun(eu_b), .err_overrun(eo_b)
  );

  // Observed instance.
  wire          o_rdreq = sel_b ? rdreq_b      : rdreq_a;
  wire          o_empty = sel_b ? fifo_empty_b : fifo_empty_a;
  wire          o_valid = sel_b ? valid_b      : valid_a;
  wire [DW-1:0] o_data  = sel_b ? data_b       : data_a;
  wire [1:0]    o_index = sel_b ? index_b      : index_a;
  wire          o_done  = sel_b ? done_b       : done_a;
  wire          o_busy  = sel_b ? busy_b       : busy_a;
  wire          o_eu    = sel_b ? eu_b         : eu_a;
  wire          o_eo    = sel_b ? eo_b         : eo_a;

  // ---------------- bookkeeping ----------------
  int n_vec  = 0;
  int n_fail = 0;

  logic [DW-1:0] tag;
  int            seq;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drop any words left over and start a new data tag.
  task automatic new_test(input logic [DW-1:0] t);
    tag = t;
    seq = 0;
    if (sel_b) wr_b = rd_b;
    else       wr_a = rd_a;
  endtask

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      if (sel_b) begin
        mem_b[wr_b] = tag | DW'(seq);
        wr_b++;
      end else begin
        mem_a[wr_a] = tag | DW'(seq);
        wr_a++;
      end
      seq++;
    end
  endtask

  // Advance one clock, drive inputs, then leave time for outputs to settle.
  task automatic step(input logic st, input logic ru);
    @(posedge clk);
    #1;
    start    = st;
    rst_user = ru;
    #1;
  endtask

  // Drain statistics gathered by run_drain.
  int n_rd, n_val, n_done, order_bad, data_bad, gaps, empty_rd;
  int first_rd, first_val, last_val, done_cyc, done_idx, ur_cyc;
  logic done_valid, eu_c1, eo_c1, busy_after, finished;

  // Pulse start in cycle 0 (and optionally again in extra_start), optionally
  // push push_n more words in push_cyc, and record everything observed until
  // the cycle after done or until max_cyc expires.
  task automatic run_drain(input int max_cyc, input int extra_start,
                           input int push_cyc, input int push_n);
    n_rd = 0; n_val = 0; n_done = 0; order_bad = 0; data_bad = 0; gaps = 0;
    empty_rd = 0; first_rd = -1; first_val = -1; last_val = -1; done_cyc = -1;
    done_idx = -1; ur_cyc = -1; done_valid = 1'b0; eu_c1 = 1'bx; eo_c1 = 1'bx;
    busy_after = 1'bx; finished = 1'b0;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      @(posedge clk);
      #1;
      start = (cyc == 0) || (cyc == extra_start);
      if (cyc == push_cyc) push(push_n);
      #1;
      if (o_rdreq) begin
        n_rd++;
        if (first_rd < 0) first_rd = cyc;
        if (o_empty) empty_rd++;
      end
      if (o_valid) begin
        if (first_val < 0) first_val = cyc;
        if (last_val >= 0 && cyc != last_val + 1) gaps++;
        if (int'(o_index) != n_val) order_bad++;
        if (o_data !== (tag | DW'(n_val))) data_bad++;
        last_val = cyc;
        n_val++;
      end
      if (o_done) begin
        n_done++;
        done_cyc   = cyc;
        done_idx   = int'(o_index);
        done_valid = o_valid;
      end
      if (o_eu && ur_cyc < 0) ur_cyc = cyc;
      if (cyc == 1) begin
        eu_c1 = o_eu;
        eo_c1 = o_eo;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        busy_after = o_busy;
        finished   = 1'b1;
        break;
      end
    end
    start = 1'b0;
  endtask

  // Full-FIFO cycle table.
  typedef struct {
    logic          start;
    logic          rdreq;
    logic          valid;
    logic [1:0]    idx;
    logic [DW-1:0] data;
    logic          done;
    logic          busy;
  } vec_t;

  vec_t tbl [8];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    // ---------------- table setup ----------------
    //         start rdreq valid idx  data                    done busy
    tbl[0] = '{1'b1, 1'b0, 1'b0, 2'd0, 64'h0,                  1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 2'd0, 64'h0,                  1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 2'd0, 64'h0,                  1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 2'd0, 64'hA000_0000_0000_0000, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 2'd1, 64'hA000_0000_0000_0001, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 2'd2, 64'hA000_0000_0000_0002, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 2'd3, 64'hA000_0000_0000_0003, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 2'd0, 64'h0,                  1'b0, 1'b0};

    // ---------------- reset ----------------
    new_test(64'h5000_0000_0000_0000);
    push(1);
    rst = 1'b1;
    step(1'b1, 1'b0);
    check("rst_rdreq_held", rdreq_a, 1'b0);
    step(1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_valid", valid_a, 1'b0);
    check("rst_data",  data_a,  '0);
    check("rst_index", index_a, '0);
    check("rst_done",  done_a,  1'b0);
    check("rst_busy",  busy_a,  1'b0);
    check("rst_eu",    eu_a,    1'b0);
    check("rst_eo",    eo_a,    1'b0);
    check("rst_rdreq", rdreq_a, 1'b0);

    // ---------------- full FIFO, table-driven ----------------
    new_test(64'hA000_0000_0000_0000);
    push(NW + 1);
    for (int k = 0; k < 8; k++) begin
      step(tbl[k].start, 1'b0);
      check($sformatf("full_c%0d_rdreq", k), rdreq_a, tbl[k].rdreq);
      check($sformatf("full_c%0d_valid", k), valid_a, tbl[k].valid);
      check($sformatf("full_c%0d_done",  k), done_a,  tbl[k].done);
      check($sformatf("full_c%0d_busy",  k), busy_a,  tbl[k].busy);
      if (tbl[k].valid) begin
        check($sformatf("full_c%0d_index", k), index_a, tbl[k].idx);
        check($sformatf("full_c%0d_data",  k), data_a,  tbl[k].data);
      end
    end
    check("full_extra_word_left", DW'(wr_a - rd_a), 1);
    check("full_eu", eu_a, 1'b0);
    check("full_eo", eo_a, 1'b0);

    // ---------------- throttled ----------------
    new_test(64'hB000_0000_0000_0000);
    push(2);
    run_drain(40, -1, 5, 2);
    check("thr_finished",  finished,  1'b1);
    check("thr_rdreq_cnt", n_rd,      NW);
    check("thr_valid_cnt", n_val,     NW);
    check("thr_order_bad", order_bad, 0);
    check("thr_data_bad",  data_bad,  0);
    check("thr_empty_rd",  empty_rd,  0);
    check("thr_gaps",      gaps,      1);
    check("thr_done_cnt",  n_done,    1);
    check("thr_done_cyc",  done_cyc,  8);
    check("thr_done_idx",  done_idx,  3);
    check("thr_eu",        o_eu,      1'b0);
    check("thr_eo",        o_eo,      1'b0);

    // ---------------- underrun ----------------
    new_test(64'hC000_0000_0000_0000);
    push(1);
    run_drain(40, -1, -1, 0);
    check("ur_finished",  finished,   1'b1);
    check("ur_rdreq_cnt", n_rd,       1);
    check("ur_valid_cnt", n_val,      1);
    check("ur_data_bad",  data_bad,   0);
    check("ur_flag_cyc",  ur_cyc,     10);
    check("ur_done_cyc",  done_cyc,   11);
    check("ur_done_cnt",  n_done,     1);
    check("ur_busy_after", busy_after, 1'b0);
    check("ur_sticky",    o_eu,       1'b1);

    new_test(64'hD000_0000_0000_0000);
    push(NW);
    run_drain(40, -1, -1, 0);
    check("ur_clear_c1",   eu_c1,    1'b0);
    check("ur_next_vals",  n_val,    NW);
    check("ur_next_done",  done_cyc, 6);

    // ---------------- overrun: start 2 cycles into a drain ----------------
    new_test(64'hE000_0000_0000_0000);
    push(NW);
    run_drain(40, 2, -1, 0);
    check("ov_flag",      o_eo,     1'b1);
    check("ov_rdreq_cnt", n_rd,     NW);
    check("ov_valid_cnt", n_val,    NW);
    check("ov_data_bad",  data_bad, 0);
    check("ov_gaps",      gaps,     0);
    check("ov_done_cnt",  n_done,   1);
    check("ov_done_cyc",  done_cyc, 6);

    // ---------------- overrun: start in the done cycle ----------------
    new_test(64'hF000_0000_0000_0000);
    push(NW);
    run_drain(40, 6, -1, 0);
    check("ovd_clear_c1",   eo_c1,      1'b0);
    check("ovd_done_cnt",   n_done,     1);
    check("ovd_busy_after", busy_after, 1'b0);
    check("ovd_flag",       o_eo,       1'b1);

    // ---------------- soft abort ----------------
    new_test(64'h1000_0000_0000_0000);
    push(NW);
    step(1'b1, 1'b0);
    for (int k = 1; k < 4; k++) step(1'b0, 1'b0);
    check("ab_c3_valid", valid_a, 1'b1);
    check("ab_c3_index", index_a, 2'd0);
    step(1'b0, 1'b1);
    check("ab_c4_valid", valid_a, 1'b1);
    check("ab_c4_index", index_a, 2'd1);
    step(1'b0, 1'b0);
    check("ab_rdreq", rdreq_a, 1'b0);
    check("ab_valid", valid_a, 1'b0);
    check("ab_data",  data_a,  '0);
    check("ab_index", index_a, '0);
    check("ab_done",  done_a,  1'b0);
    check("ab_busy",  busy_a,  1'b0);
    check("ab_eu",    eu_a,    1'b0);
    check("ab_eo",    eo_a,    1'b0);
    n_val = 0;
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b0);
      if (valid_a || done_a || rdreq_a) n_val++;
    end
    check("ab_quiet_after", n_val, 0);

    // ---------------- RD_LATENCY = 3 ----------------
    sel_b = 1'b1;
    new_test(64'h3000_0000_0000_0000);
    push(NW);
    run_drain(40, -1, -1, 0);
    check("l3_finished",  finished,             1'b1);
    check("l3_first_rd",  first_rd,             1);
    check("l3_latency",   first_val - first_rd, 4);
    check("l3_valid_cnt", n_val,                NW);
    check("l3_gaps",      gaps,                 0);
    check("l3_data_bad",  data_bad,             0);
    check("l3_done_cyc",  done_cyc,             8);
    check("l3_done_idx",  done_idx,             3);
    check("l3_done_val",  done_valid,           1'b1);
    check("l3_busy_after", busy_after,          1'b0);
    sel_b = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
